ebus_io_seq: RTL and testbench

- EBUS I/O transaction sequencer between the EBOX (CON/MCL I/O instruction control) and the EBUS device side (DTE, PI, external controllers).
- Takes one I/O request (CONO, CONI, DATAO, DATAI) from the EBOX and arbitrates for the bus.
- Runs the select/demand/transfer handshake with the addressed device, with timeout, and returns read data plus a completion/error pulse to the EBOX.

---
 rtl/ebus_io_seq.sv | 200 ++++++++++++++++++++
 tb/tb_ebus_io_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_io_seq.sv
// EBUS I/O transaction sequencer: takes one CONO/CONI/DATAO/DATAI request from the EBOX,
// arbitrates for the bus, runs select/demand/transfer with timeout and returns status and read data.
module ebus_io_seq #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk30,
    input  logic        CROBAR_n,
    input  logic        ioReq,
    input  logic [1:0]  ioFunc,
    input  logic [6:0]  ioDev,
    input  logic [35:0] ioDataOut,
    output logic        ioBusy,
    output logic        ioDone,
    output logic        ioErr,
    output logic [35:0] ioDataIn,
    output logic        ebusReq,
    input  logic        ebusGrant,
    output logic [6:0]  ebusCS,
    output logic [1:0]  ebusFunc,
    output logic        ebusDemand,
    input  logic        ebusXfer,
    output logic [35:0] ebusDataOut,
    output logic        ebusDataDrive,
    input  logic [35:0] ebusDataIn
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned CNT_P1_W = CNT_W + 1;
    localparam int unsigned FUNC_W   = 2;
    localparam int unsigned DEV_W    = 7;
    localparam int unsigned DATA_W   = 36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_DEMAND,
        S_RELEASE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [CNT_P1_W-1:0] cnt_p1;
    logic                setup_end, hold_end, tmo_end;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic [DEV_W-1:0]    dev_q, dev_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                bus_on, write_on;
    logic                busy_d, done_d, ioerr_d, req_d, demand_d, drive_d;
    logic [DEV_W-1:0]    cs_d;
    logic [FUNC_W-1:0]   efunc_d;
    logic [DATA_W-1:0]   dout_d;

    // cnt_p1 is the number of cycles completed in the current phase, including this one
    assign cnt_p1    = {1'b0, cnt_q} + CNT_P1_W'(1);
    assign cnt_inc   = cnt_p1[CNT_W] ? cnt_q : cnt_p1[CNT_W-1:0];
    assign setup_end = cnt_p1 >= CNT_P1_W'(SETUP_CYC);
    assign hold_end  = cnt_p1 >= CNT_P1_W'(HOLD_CYC);
    assign tmo_end   = cnt_p1 >= CNT_P1_W'(TIMEOUT_CYC);

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        dev_d   = dev_q;
        data_d  = data_q;
        err_d   = err_q;
        rdata_d = ioDataIn;

        case (state_q)
            S_IDLE: begin
                if (ioReq) begin
                    state_d = S_ARB;
                    func_d  = ioFunc;
                    dev_d   = ioDev;
                    data_d  = ioDataOut;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                end
            end
            S_ARB: begin
                if (ebusGrant) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (setup_end) begin
                    state_d = S_DEMAND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DEMAND: begin
                // An acknowledge on the last allowed cycle still wins over the timeout
                if (ebusXfer) begin
                    if (func_q[0]) begin
                        rdata_d = ebusDataIn;
                    end
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (tmo_end) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                if (!ebusXfer || tmo_end) begin
                    if (ebusXfer) begin
                        err_d = 1'b1;
                    end
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLD: begin
                if (hold_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus_on   = (state_d == S_SETUP) || (state_d == S_DEMAND) ||
                   (state_d == S_RELEASE) || (state_d == S_HOLD);
        write_on = bus_on && !func_d[0];
        busy_d   = (state_d != S_IDLE);
        req_d    = bus_on || (state_d == S_ARB);
        demand_d = (state_d == S_DEMAND);
        cs_d     = bus_on ? dev_d : '0;
        efunc_d  = bus_on ? func_d : '0;
        drive_d  = write_on;
        dout_d   = write_on ? data_d : '0;
        done_d   = (state_d == S_DONE);
        ioerr_d  = done_d && err_d;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk30 or negedge CROBAR_n) begin
        if (!CROBAR_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            func_q        <= '0;
            dev_q         <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            ioBusy        <= 1'b0;
            ioDone        <= 1'b0;
            ioErr         <= 1'b0;
            ioDataIn      <= '0;
            ebusReq       <= 1'b0;
            ebusCS        <= '0;
            ebusFunc      <= '0;
            ebusDemand    <= 1'b0;
            ebusDataOut   <= '0;
            ebusDataDrive <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            func_q        <= func_d;
            dev_q         <= dev_d;
            data_q        <= data_d;
            err_q         <= err_d;
            ioBusy        <= busy_d;
            ioDone        <= done_d;
            ioErr         <= ioerr_d;
            ioDataIn      <= rdata_d;
            ebusReq       <= req_d;
            ebusCS        <= cs_d;
            ebusFunc      <= efunc_d;
            ebusDemand    <= demand_d;
            ebusDataOut   <= dout_d;
            ebusDataDrive <= drive_d;
        end
    end

endmodule

// File: tb/tb_ebus_io_seq.sv
// Bench for ebus_io_seq: reactive device/arbiter, phase-length model of each transaction,
// per-cycle output comparison plus directed literal checks.
module tb_ebus_io_seq;

    localparam int SETUP = 2;
    localparam int HOLD  = 1;
    localparam int TO    = 64;

    logic        clk30;
    logic        CROBAR_n;
    logic        ioReq;
    logic [1:0]  ioFunc;
    logic [6:0]  ioDev;
    logic [35:0] ioDataOut;
    logic        ioBusy, ioDone, ioErr;
    logic [35:0] ioDataIn;
    logic        ebusReq, ebusGrant;
    logic [6:0]  ebusCS;
    logic [1:0]  ebusFunc;
    logic        ebusDemand, ebusXfer;
    logic [35:0] ebusDataOut;
    logic        ebusDataDrive;
    logic [35:0] ebusDataIn;

    ebus_io_seq #(.SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TO)) dut (
        .clk30(clk30), .CROBAR_n(CROBAR_n), .ioReq(ioReq), .ioFunc(ioFunc), .ioDev(ioDev),
        .ioDataOut(ioDataOut), .ioBusy(ioBusy), .ioDone(ioDone), .ioErr(ioErr),
        .ioDataIn(ioDataIn), .ebusReq(ebusReq), .ebusGrant(ebusGrant), .ebusCS(ebusCS),
        .ebusFunc(ebusFunc), .ebusDemand(ebusDemand), .ebusXfer(ebusXfer),
        .ebusDataOut(ebusDataOut), .ebusDataDrive(ebusDataDrive), .ebusDataIn(ebusDataIn)
    );

    initial clk30 = 1'b0;
    always #5 clk30 = ~clk30;

    int checks = 0;
    int failures = 0;

    // device behaviour for the current transaction
    int          cur_g, cur_d, cur_r;
    bit          cur_absent, cur_pre, cur_drop;
    logic [35:0] cur_rdata;

    // model: one transaction described by its phase lengths
    bit          m_act;
    int          m_k, m_a, m_dl, m_rl, m_total;
    bit          m_err;
    logic [1:0]  m_func;
    logic [6:0]  m_dev;
    logic [35:0] m_data, m_res, m_last;

    // stats gathered per directed test
    int          st_cyc, dones, dem_cyc, drive_pre, post_dem, idle_cyc, done_cyc;
    bit          seen_dem, drive_any, last_err, req_at_done;
    logic [6:0]  cs_at_dem;
    logic [1:0]  func_at_dem;
    logic [35:0] last_din;

    function automatic int clampto(input int v);
        return (v > TO) ? TO : v;
    endfunction

    function automatic int dem_len();
        return cur_absent ? TO : clampto(cur_d + 1);
    endfunction

    function automatic int rel_len();
        return cur_absent ? 1 : clampto(cur_r + 1);
    endfunction

    always @(posedge clk30 or negedge CROBAR_n) begin
        if (!CROBAR_n) begin
            m_act  <= 1'b0;
            m_k    <= 0;
            m_last <= '0;
        end else if (m_act) begin
            if (m_k == m_total) begin
                m_act  <= 1'b0;
                m_last <= m_res;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (ioReq) begin
            m_act   <= 1'b1;
            m_k     <= 0;
            m_func  <= ioFunc;
            m_dev   <= ioDev;
            m_data  <= ioDataOut;
            m_a     <= cur_g + 1;
            m_dl    <= dem_len();
            m_rl    <= rel_len();
            m_total <= cur_g + 1 + SETUP + dem_len() + rel_len() + HOLD;
            m_err   <= cur_absent || (cur_r + 1 > TO);
            m_res   <= (ioFunc[0] && !cur_absent) ? cur_rdata : '0;
        end
    end

    // arbiter and device, reacting to DUT outputs on the falling edge
    initial begin
        int          phase, req_cnt, dcnt, rcnt;
        logic [63:0] junk;
        phase = 0; req_cnt = 0; dcnt = 0; rcnt = 0;
        ebusGrant = 1'b0; ebusXfer = 1'b0; ebusDataIn = '0;
        forever begin
            @(negedge clk30);
            if (!CROBAR_n) begin
                phase = 0; req_cnt = 0;
                ebusGrant = 1'b0; ebusXfer = 1'b0;
            end else begin
                if (!ebusReq && phase != 2) phase = 0;
                if (ebusReq) begin
                    ebusGrant = (req_cnt >= cur_g) && !(cur_drop && phase != 0);
                    if (req_cnt < 1000) req_cnt++;
                end else begin
                    ebusGrant = 1'b0;
                    req_cnt = 0;
                end
                if (ebusDemand) begin
                    if (phase == 0) begin
                        phase = 1;
                        dcnt = 0;
                    end
                    ebusXfer = !cur_absent && (dcnt >= cur_d);
                    dcnt++;
                end else if (phase == 1 || phase == 2) begin
                    if (phase == 1) begin
                        phase = 2;
                        rcnt = 0;
                    end
                    if (rcnt >= cur_r) ebusXfer = 1'b0;
                    rcnt++;
                    if (!ebusXfer) phase = 3;
                end else if (phase == 0 && cur_pre && ebusGrant && ebusReq) begin
                    ebusXfer = 1'b1;
                end
                junk = {$urandom, $urandom};
                ebusDataIn = ebusXfer ? cur_rdata : junk[35:0];
            end
        end
    end

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        st_cyc = 0; dones = 0; dem_cyc = 0; drive_pre = 0; post_dem = 0; idle_cyc = 0;
        done_cyc = -1; seen_dem = 0; drive_any = 0; last_err = 0; req_at_done = 0;
        cs_at_dem = '0; func_at_dem = '0; last_din = '0;
    endtask

    // advance one cycle, compare every output against the model, gather stats
    task automatic tick();
        logic        e_busy, e_req, e_bus, e_dem, e_done, e_err, e_drv;
        logic [35:0] e_din;
        int          e1, e2, e3;
        @(negedge clk30);
        if (m_act) begin
            e1 = m_a; e2 = e1 + SETUP; e3 = e2 + m_dl;
            e_busy = 1'b1;
            e_req  = m_k < m_total;
            e_bus  = (m_k >= e1) && (m_k < m_total);
            e_dem  = (m_k >= e2) && (m_k < e3);
            e_done = m_k == m_total;
            e_err  = e_done && m_err;
            e_drv  = e_bus && !m_func[0];
            e_din  = (m_k >= e3) ? m_res : '0;
        end else begin
            e_busy = 0; e_req = 0; e_bus = 0; e_dem = 0; e_done = 0; e_err = 0; e_drv = 0;
            e_din = m_last;
        end
        chk("ioBusy", 36'(ioBusy), 36'(e_busy));
        chk("ioDone", 36'(ioDone), 36'(e_done));
        chk("ioErr", 36'(ioErr), 36'(e_err));
        chk("ioDataIn", ioDataIn, e_din);
        chk("ebusReq", 36'(ebusReq), 36'(e_req));
        chk("ebusCS", 36'(ebusCS), e_bus ? 36'(m_dev) : 36'(0));
        chk("ebusFunc", 36'(ebusFunc), e_bus ? 36'(m_func) : 36'(0));
        chk("ebusDemand", 36'(ebusDemand), 36'(e_dem));
        chk("ebusDataDrive", 36'(ebusDataDrive), 36'(e_drv));
        chk("ebusDataOut", ebusDataOut, e_drv ? m_data : 36'(0));

        if (ebusDemand) begin
            dem_cyc++;
            if (!seen_dem) begin
                cs_at_dem = ebusCS;
                func_at_dem = ebusFunc;
            end
        end
        if (ebusDataDrive && !seen_dem && !ebusDemand) drive_pre++;
        if (ebusDemand) seen_dem = 1;
        if (ebusDataDrive) drive_any = 1;
        if (seen_dem && ioBusy && !ebusDemand && !ioDone) post_dem++;
        if (!ioBusy) idle_cyc++;
        if (ioDone) begin
            if (dones == 0) done_cyc = st_cyc;
            dones++;
            last_err = ioErr;
            last_din = ioDataIn;
            req_at_done = ebusReq;
        end
        st_cyc++;
    endtask

    task automatic start_txn(input logic [1:0] f, input logic [6:0] dv, input logic [35:0] dat,
                             input int g, input int d, input bit absent, input int r,
                             input bit pre, input bit drop, input logic [35:0] rd, input bit keep);
        cur_g = g; cur_d = d; cur_absent = absent; cur_r = r;
        cur_pre = pre; cur_drop = drop; cur_rdata = rd;
        ioFunc = f; ioDev = dv; ioDataOut = dat; ioReq = 1'b1;
        clear_stats();
        tick();
        if (!keep) ioReq = 1'b0;
    endtask

    // mode 0: inputs quiet, 1: scramble fields, 2: scramble fields and ioReq
    task automatic run_until(input int n, input int bound, input int mode);
        logic [63:0] rnd;
        int i;
        for (i = 0; i < bound && dones < n; i++) begin
            if (mode != 0) begin
                rnd = {$urandom, $urandom};
                ioFunc = rnd[1:0]; ioDev = rnd[8:2]; ioDataOut = rnd[44:9];
                if (mode == 2) ioReq = rnd[45];
            end
            tick();
        end
        checks++;
        if (dones < n) begin
            failures++;
            $display("FAIL done_wait actual=%0d expected=%0d", dones, n);
        end
    endtask

    initial begin
        logic [63:0] rnd;
        int          wait_n;
        CROBAR_n = 1'b0; ioReq = 1'b0; ioFunc = '0; ioDev = '0; ioDataOut = '0;
        cur_g = 0; cur_d = 0; cur_r = 0; cur_absent = 0; cur_pre = 0; cur_drop = 0;
        cur_rdata = '0;
        clear_stats();
        tick(); tick();
        chk("reset_outs", 36'(|{ioBusy, ioDone, ioErr, ioDataIn, ebusReq, ebusCS, ebusFunc,
                                ebusDemand, ebusDataOut, ebusDataDrive}), 36'(0));
        #2 CROBAR_n = 1'b1;
        tick();

        // reset mid-DEMAND on a DATAO to an absent device
        start_txn(2'd2, 7'o020, 36'o123456_654321, 1, 0, 1, 0, 0, 0, '0, 0);
        wait_n = 0;
        while (!ebusDemand && wait_n < 30) begin
            tick();
            wait_n++;
        end
        chk("demand_reached", 36'(ebusDemand), 36'(1));
        tick(); tick(); tick();
        #2 CROBAR_n = 1'b0;
        #1 chk("abort_outs", 36'(|{ioBusy, ioDone, ioErr, ioDataIn, ebusReq, ebusCS, ebusFunc,
                                   ebusDemand, ebusDataOut, ebusDataDrive}), 36'(0));
        tick(); tick();
        chk("abort_no_done", 36'(dones), 36'(0));
        #2 CROBAR_n = 1'b1;
        tick();

        // CONO, prompt grant and xfer
        start_txn(2'd0, 7'o004, 36'o000000_012345, 0, 0, 0, 0, 0, 0, '0, 0);
        run_until(1, 100, 0);
        chk("cono_drive_pre", 36'(drive_pre), 36'(2));
        chk("cono_cs", 36'(cs_at_dem), 36'(7'o004));
        chk("cono_func", 36'(func_at_dem), 36'(0));
        chk("cono_err", 36'(last_err), 36'(0));
        chk("cono_req_done", 36'(req_at_done), 36'(0));
        chk("cono_latency", 36'(done_cyc), 36'(6));
        ioReq = 1'b0; tick();

        // DATAI with xfer 5 cycles into DEMAND
        start_txn(2'd3, 7'o010, 36'o0, 1, 5, 0, 1, 0, 0, 36'o777000_123456, 0);
        run_until(1, 100, 0);
        chk("datai_data", last_din, 36'o777000_123456);
        chk("datai_nodrive", 36'(drive_any), 36'(0));
        chk("datai_demcyc", 36'(dem_cyc), 36'(6));
        chk("datai_err", 36'(last_err), 36'(0));
        ioReq = 1'b0; tick();

        // CONI to absent device
        start_txn(2'd1, 7'o070, 36'o0, 0, 0, 1, 0, 0, 0, 36'o555, 0);
        run_until(1, 200, 0);
        chk("tmo_demcyc", 36'(dem_cyc), 36'(64));
        chk("tmo_err", 36'(last_err), 36'(1));
        chk("tmo_data", last_din, 36'(0));
        chk("tmo_post", 36'(post_dem), 36'(2));
        ioReq = 1'b0; tick();

        // DATAO with xfer stuck 100 cycles after demand drops
        start_txn(2'd2, 7'o044, 36'o707070_070707, 0, 2, 0, 100, 0, 0, '0, 0);
        run_until(1, 200, 0);
        chk("stuck_post", 36'(post_dem), 36'(65));
        chk("stuck_err", 36'(last_err), 36'(1));
        ioReq = 1'b0;
        repeat (45) tick();

        // back-to-back with ioReq held high, fields scrambled mid-transaction
        start_txn(2'd2, 7'o030, 36'o111111_222222, 3, 0, 0, 0, 0, 0, 36'o333, 1);
        run_until(2, 100, 1);
        chk("b2b_dones", 36'(dones), 36'(2));
        chk("b2b_idle_gap", 36'(idle_cyc), 36'(1));
        chk("b2b_cs", 36'(cs_at_dem), 36'(7'o030));
        chk("b2b_latency", 36'(done_cyc), 36'(9));
        ioReq = 1'b0; tick();

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            rnd = {$urandom, $urandom};
            cur_absent = ($urandom_range(0, 7) == 0);
            cur_pre = !cur_absent && ($urandom_range(0, 3) == 0);
            start_txn(rnd[1:0], rnd[8:2], rnd[44:9], $urandom_range(0, 4),
                      cur_pre ? 0 : $urandom_range(0, 8), cur_absent, $urandom_range(0, 5),
                      cur_pre, 1'($urandom_range(0, 1)), {rnd[63:46], rnd[17:0]}, 0);
            run_until(1, 300, 2);
            ioReq = 1'b0;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
